// File: rtl/rs_entry_alloc.sv
// Dispatch-side allocator for the reservation station: owns entry valid bits, hands out
// up to two free entries per cycle (slot 0 from the low end, slot 1 from the high end).
module rs_entry_alloc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N),
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       disp_req,
  input  logic [N-1:0]     free_mask,
  input  logic             squash,
  output logic [1:0]       alloc_gnt,
  output logic [N-1:0]     alloc_oh0,
  output logic [N-1:0]     alloc_oh1,
  output logic [IDX_W-1:0] alloc_idx0,
  output logic [IDX_W-1:0] alloc_idx1,
  output logic [N-1:0]     valid_out,
  output logic [CNT_W-1:0] free_cnt,
  output logic             full,
  output logic             stall,
  output logic [IDX_W-1:0] rr_sel
);

  localparam logic [N-1:0] ONE_HOT_LSB = {{(N-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [IDX_W-1:0] highest_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  logic [N-1:0]     valid_q, valid_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [N-1:0]     free_set;
  logic [CNT_W-1:0] free_count;
  logic [IDX_W-1:0] lo_idx, hi_idx;
  logic             gnt0, gnt1;
  logic [N-1:0]     oh0, oh1;

  // Grant selection from the registered free set; freed entries become usable next cycle.
  always_comb begin
    free_set   = ~valid_q;
    free_count = popcount(free_set);
    lo_idx     = lowest_idx(free_set);
    hi_idx     = highest_idx(free_set);
    // Slot 1 needs slot 0 too (in-order dispatch) and a second free entry so the ends never meet.
    gnt0       = disp_req[0] & (free_count >= CNT_W'(1'b1)) & ~squash;
    gnt1       = disp_req[1] & disp_req[0] & (free_count >= CNT_W'(2'd2)) & ~squash;
    if (gnt0) begin
      oh0 = ONE_HOT_LSB << lo_idx;
    end else begin
      oh0 = '0;
    end
    if (gnt1) begin
      oh1 = ONE_HOT_LSB << hi_idx;
    end else begin
      oh1 = '0;
    end
  end

  // Next-state: reset beats squash beats normal free/allocate update.
  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    if (reset) begin
      valid_d = '0;
      rr_d    = '0;
    end else if (squash) begin
      valid_d = '0;
      rr_d    = rr_q;
    end else begin
      valid_d = (valid_q & ~free_mask) | oh0 | oh1;
      if (|(free_mask & valid_q)) begin
        rr_d = rr_q + IDX_W'(1'b1);
      end else begin
        rr_d = rr_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    valid_q <= valid_d;
    rr_q    <= rr_d;
  end

  assign alloc_gnt  = {gnt1, gnt0};
  assign alloc_oh0  = oh0;
  assign alloc_oh1  = oh1;
  assign alloc_idx0 = gnt0 ? lo_idx : '0;
  assign alloc_idx1 = gnt1 ? hi_idx : '0;
  assign valid_out  = valid_q;
  assign free_cnt   = free_count;
  assign full       = (free_count == '0);
  assign stall      = (|disp_req) & ({gnt1, gnt0} != disp_req);
  assign rr_sel     = rr_q;

endmodule

// File: tb/tb_rs_entry_alloc.sv
// Self-checking bench for rs_entry_alloc: a reference model pushes the expected output
// snapshot for each driven cycle; each test task pops and compares it against the DUT.
module tb_rs_entry_alloc;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] disp_req;
  logic [7:0] free_mask;
  logic       squash;
  logic [1:0] alloc_gnt;
  logic [7:0] alloc_oh0, alloc_oh1;
  logic [2:0] alloc_idx0, alloc_idx1;
  logic [7:0] valid_out;
  logic [3:0] free_cnt;
  logic       full, stall;
  logic [2:0] rr_sel;

  rs_entry_alloc #(.N(8)) dut (
    .clock(clock), .reset(reset), .disp_req(disp_req), .free_mask(free_mask),
    .squash(squash), .alloc_gnt(alloc_gnt), .alloc_oh0(alloc_oh0), .alloc_oh1(alloc_oh1),
    .alloc_idx0(alloc_idx0), .alloc_idx1(alloc_idx1), .valid_out(valid_out),
    .free_cnt(free_cnt), .full(full), .stall(stall), .rr_sel(rr_sel)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] gnt;
    logic [7:0] oh0;
    logic [7:0] oh1;
    logic [2:0] idx0;
    logic [2:0] idx1;
    logic       stall;
    logic [3:0] cnt;
    logic       full;
    logic [7:0] valid;
    logic [2:0] rr;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       obs_s;
  rec_t       e;
  logic [7:0] m_valid = 8'h00;
  logic [2:0] m_rr = 3'd0;
  int         checks = 0;
  int         failures = 0;

  assign obs_s = {alloc_gnt, alloc_oh0, alloc_oh1, alloc_idx0, alloc_idx1, stall,
                  free_cnt, full, valid_out, rr_sel};

  // Drive one cycle of inputs, push the model's expected snapshot, advance the model.
  task automatic drive(input logic r, input logic [1:0] d, input logic [7:0] fm, input logic s);
    rec_t       x;
    logic [7:0] f;
    int         c, lo, hi;
    logic       g0, g1;
    @(negedge clock);
    reset = r; disp_req = d; free_mask = fm; squash = s;
    f  = ~m_valid;
    c  = $countones(f);
    lo = 0;
    hi = 0;
    for (int i = 0; i < 8; i++) if (f[i]) begin lo = i; break; end
    for (int i = 7; i >= 0; i--) if (f[i]) begin hi = i; break; end
    g0 = d[0] && (c >= 1) && !s;
    g1 = d[0] && d[1] && (c >= 2) && !s;
    x.gnt   = {g1, g0};
    x.oh0   = g0 ? (8'b1 << lo) : 8'h00;
    x.oh1   = g1 ? (8'b1 << hi) : 8'h00;
    x.idx0  = g0 ? 3'(lo) : 3'd0;
    x.idx1  = g1 ? 3'(hi) : 3'd0;
    x.stall = (d != 2'b00) && (x.gnt != d);
    x.cnt   = 4'(c);
    x.full  = (c == 0);
    x.valid = m_valid;
    x.rr    = m_rr;
    exp_q.push_back(x);
    if (r) begin
      m_valid = 8'h00;
      m_rr    = 3'd0;
    end else if (s) begin
      m_valid = 8'h00;
    end else begin
      if (|(fm & m_valid)) m_rr = m_rr + 3'd1;
      m_valid = (m_valid & ~fm) | x.oh0 | x.oh1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b00, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    drive(1'b1, 2'b00, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL reset_sb got=%h want=%h", obs_s, e); end
    checks++;
    if ({valid_out, rr_sel, free_cnt, full, alloc_gnt, stall} !== {8'h00, 3'd0, 4'd8, 1'b0, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h/%h/%h/%b/%b/%b want=00/0/8/0/00/0",
               valid_out, rr_sel, free_cnt, full, alloc_gnt, stall);
    end
  endtask

  task automatic test_dual_alloc();
    drive(1'b0, 2'b11, 8'h00, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL dual_sb got=%h want=%h", obs_s, e); end
    checks++;
    if ({alloc_idx0, alloc_idx1, alloc_gnt} !== {3'd0, 3'd7, 2'b11}) begin
      failures++;
      $display("FAIL dual_first got=%0d/%0d/%b want=0/7/11", alloc_idx0, alloc_idx1, alloc_gnt);
    end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL dual_sb got=%h want=%h", obs_s, e); end
    checks++;
    if ({valid_out, free_cnt} !== {8'h81, 4'd6}) begin
      failures++; $display("FAIL dual_valid got=%h/%0d want=81/6", valid_out, free_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b11, 8'h00, 1'b0);
      e = exp_q.pop_front(); checks++;
      if (obs_s !== e) begin failures++; $display("FAIL fill_sb k=%0d got=%h want=%h", k, obs_s, e); end
    end
    checks++;
    if ({valid_out, full, alloc_gnt, stall} !== {8'hFF, 1'b1, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL full_req got=%h/%b/%b/%b want=ff/1/00/1", valid_out, full, alloc_gnt, stall);
    end
  endtask

  task automatic test_free_then_alloc();
    drive(1'b0, 2'b01, 8'h10, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL freealloc_sb got=%h want=%h", obs_s, e); end
    checks++;
    if (alloc_gnt !== 2'b00) begin failures++; $display("FAIL freed_same_cycle got=%b want=00", alloc_gnt); end
    drive(1'b0, 2'b01, 8'h00, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL freealloc_sb got=%h want=%h", obs_s, e); end
    checks++;
    if ({alloc_idx0, alloc_gnt, rr_sel} !== {3'd4, 2'b01, 3'd1}) begin
      failures++;
      $display("FAIL freed_next got=%0d/%b/%0d want=4/01/1", alloc_idx0, alloc_gnt, rr_sel);
    end
  endtask

  task automatic test_single_free();
    drive(1'b0, 2'b00, 8'h01, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL single_sb got=%h want=%h", obs_s, e); end
    drive(1'b0, 2'b11, 8'h00, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL single_sb got=%h want=%h", obs_s, e); end
    checks++;
    if ({valid_out, alloc_gnt, alloc_idx0, alloc_oh1, stall} !== {8'hFE, 2'b01, 3'd0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL single_grant got=%h/%b/%0d/%h/%b want=fe/01/0/00/1",
               valid_out, alloc_gnt, alloc_idx0, alloc_oh1, stall);
    end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL single_sb got=%h want=%h", obs_s, e); end
    checks++;
    if (valid_out !== 8'hFF) begin failures++; $display("FAIL single_next got=%h want=ff", valid_out); end
  endtask

  task automatic test_squash();
    drive(1'b0, 2'b00, 8'hC3, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL squash_sb got=%h want=%h", obs_s, e); end
    drive(1'b0, 2'b11, 8'h04, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL squash_sb got=%h want=%h", obs_s, e); end
    checks++;
    if ({valid_out, alloc_gnt} !== {8'h3C, 2'b00}) begin
      failures++; $display("FAIL squash_grant got=%h/%b want=3c/00", valid_out, alloc_gnt);
    end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL squash_sb got=%h want=%h", obs_s, e); end
    checks++;
    if ({valid_out, rr_sel} !== {8'h00, 3'd3}) begin
      failures++; $display("FAIL squash_next got=%h/%0d want=00/3", valid_out, rr_sel);
    end
  endtask

  task automatic test_rr_wrap();
    drive(1'b0, 2'b00, 8'h01, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL rr_sb got=%h want=%h", obs_s, e); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b11, 8'h00, 1'b0);
      e = exp_q.pop_front(); checks++;
      if (obs_s !== e) begin failures++; $display("FAIL rr_fill_sb got=%h want=%h", obs_s, e); end
    end
    // One issue per cycle on a full station; rr_sel starts at 3 and must wrap through 0.
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 2'b01, 8'b1 << (k % 8), 1'b0);
      e = exp_q.pop_front(); checks++;
      if (obs_s !== e) begin failures++; $display("FAIL rr_issue_sb k=%0d got=%h want=%h", k, obs_s, e); end
      checks++;
      if (rr_sel !== 3'(3 + k)) begin
        failures++; $display("FAIL rr_seq k=%0d got=%0d want=%0d", k, rr_sel, 3'(3 + k));
      end
    end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL rr_sb got=%h want=%h", obs_s, e); end
    checks++;
    if (rr_sel !== 3'd7) begin failures++; $display("FAIL rr_end got=%0d want=7", rr_sel); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'b00, 8'h0F, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL rstmid_sb got=%h want=%h", obs_s, e); end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_s !== e) begin failures++; $display("FAIL rstmid_sb got=%h want=%h", obs_s, e); end
    checks++;
    if ({valid_out, rr_sel, free_cnt} !== {8'h00, 3'd0, 4'd8}) begin
      failures++; $display("FAIL rstmid_state got=%h/%0d/%0d want=00/0/8", valid_out, rr_sel, free_cnt);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
            8'($urandom) & 8'($urandom), ($urandom_range(0, 19) == 0));
      e = exp_q.pop_front(); checks++;
      if (obs_s !== e) begin failures++; $display("FAIL random_sb k=%0d got=%h want=%h", k, obs_s, e); end
    end
  endtask

  initial begin
    reset = 1'b1; disp_req = 2'b00; free_mask = 8'h00; squash = 1'b0;
    test_reset();
    test_dual_alloc();
    test_free_then_alloc();
    test_single_free();
    test_squash();
    test_rr_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
